// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control FSM.
// Also holds the DECODE-stage opcode dispatch.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEM_ADDR,
        MEM_READ,
        MEM_WB,
        MEM_WRITE,
        EXEC_R,
        EXEC_I,
        EXEC_LUI,
        EXEC_AUIPC,
        ALU_WB,
        BRANCH,
        JAL,
        EXEC_JALR,
        TRAP
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_RI  = 2'b10;
    localparam logic [1:0] ALUOP_JL  = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_RS1   = 2'd2;

    localparam logic [1:0] SRCB_RS2  = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;

    localparam logic [1:0] RES_ALUOUT    = 2'd0;
    localparam logic [1:0] RES_MEMDATA   = 2'd1;
    localparam logic [1:0] RES_ALURESULT = 2'd2;

    typedef struct packed {
        logic [1:0] alu_op;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       adr_src;
        logic       mem_req;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       reg_write;
        logic       instr_retired;
        logic       illegal_instr;
    } ctrl_t;

    function automatic state_e decode_target(input logic [6:0] opcode);
        state_e s;
        case (opcode)
            OP_LOAD, OP_STORE: s = MEM_ADDR;
            OP_RTYPE:          s = EXEC_R;
            OP_ITYPE:          s = EXEC_I;
            OP_LUI:            s = EXEC_LUI;
            OP_AUIPC:          s = EXEC_AUIPC;
            OP_BRANCH:         s = BRANCH;
            OP_JAL:            s = JAL;
            OP_JALR:           s = EXEC_JALR;
            default:           s = TRAP;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on memory; flags expiry at MEM_TIMEOUT.
// MEM_TIMEOUT of 0 removes the counter and never expires.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic waiting,
    output logic expired
);

    generate
        if (MEM_TIMEOUT == 0) begin : g_no_timer
            logic w_unused_inputs;
            assign w_unused_inputs = ^{clk, rst_n, clear, waiting};
            assign expired         = 1'b0;
        end else begin : g_timer
            localparam int CW = $clog2(MEM_TIMEOUT + 1);
            localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

            logic [CW-1:0] r_count;

            // Wait counter, saturating at the limit so it cannot wrap.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_count <= {CW{1'b0}};
                end else if (clear) begin
                    r_count <= {CW{1'b0}};
                end else if (waiting && (r_count != LIMIT)) begin
                    r_count <= r_count + CW'(1);
                end else begin
                    r_count <= r_count;
                end
            end

            assign expired = (r_count == LIMIT);
        end
    endgenerate

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I datapath: sequences each
// instruction and drives datapath selects, write enables and memory handshake.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] Opcode,
    input  logic       MemReady,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       AdrSrc,
    output logic       MemReq,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       RegWrite,
    output logic       InstrRetired,
    output logic       IllegalInstr
);

    state_e r_state;
    state_e w_state_next;
    ctrl_t  w_ctrl;
    logic   w_timer_clear;
    logic   w_timer_waiting;
    logic   w_timer_expired;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a ready memory beats a simultaneous timeout.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FETCH: begin
                if (MemReady)             w_state_next = DECODE;
                else if (w_timer_expired) w_state_next = TRAP;
                else                      w_state_next = FETCH;
            end
            DECODE:   w_state_next = decode_target(Opcode);
            MEM_ADDR: begin
                if (Opcode == OP_STORE) w_state_next = MEM_WRITE;
                else                    w_state_next = MEM_READ;
            end
            MEM_READ: begin
                if (MemReady)             w_state_next = MEM_WB;
                else if (w_timer_expired) w_state_next = TRAP;
                else                      w_state_next = MEM_READ;
            end
            MEM_WRITE: begin
                if (MemReady)             w_state_next = FETCH;
                else if (w_timer_expired) w_state_next = TRAP;
                else                      w_state_next = MEM_WRITE;
            end
            EXEC_R, EXEC_I, EXEC_LUI, EXEC_AUIPC: w_state_next = ALU_WB;
            MEM_WB, ALU_WB, BRANCH, JAL:          w_state_next = FETCH;
            EXEC_JALR: w_state_next = JAL;
            TRAP:      w_state_next = TRAP;
            default:   w_state_next = TRAP;
        endcase
    end

    // Output decode; everything is held low while reset is asserted.
    always_comb begin
        w_ctrl = '0;
        if (!rst_n) begin
            w_ctrl = '0;
        end else begin
            case (r_state)
                FETCH: begin
                    w_ctrl.mem_req   = 1'b1;
                    w_ctrl.adr_src   = 1'b0;
                    w_ctrl.alu_src_a = SRCA_PC;
                    w_ctrl.alu_src_b = SRCB_FOUR;
                    w_ctrl.alu_op    = ALUOP_ADD;
                    w_ctrl.ir_write  = MemReady;
                    w_ctrl.pc_write  = MemReady;
                end
                DECODE, EXEC_AUIPC: begin
                    w_ctrl.alu_src_a = SRCA_OLDPC;
                    w_ctrl.alu_src_b = SRCB_IMM;
                    w_ctrl.alu_op    = ALUOP_ADD;
                end
                MEM_ADDR, EXEC_JALR: begin
                    w_ctrl.alu_src_a = SRCA_RS1;
                    w_ctrl.alu_src_b = SRCB_IMM;
                    w_ctrl.alu_op    = ALUOP_ADD;
                end
                MEM_READ: begin
                    w_ctrl.mem_req = 1'b1;
                    w_ctrl.adr_src = 1'b1;
                end
                MEM_WB: begin
                    w_ctrl.result_src    = RES_MEMDATA;
                    w_ctrl.reg_write     = 1'b1;
                    w_ctrl.instr_retired = 1'b1;
                end
                MEM_WRITE: begin
                    w_ctrl.mem_req       = 1'b1;
                    w_ctrl.mem_write     = 1'b1;
                    w_ctrl.adr_src       = 1'b1;
                    w_ctrl.instr_retired = MemReady;
                end
                EXEC_R: begin
                    w_ctrl.alu_src_a = SRCA_RS1;
                    w_ctrl.alu_src_b = SRCB_RS2;
                    w_ctrl.alu_op    = ALUOP_RI;
                end
                EXEC_I: begin
                    w_ctrl.alu_src_a = SRCA_RS1;
                    w_ctrl.alu_src_b = SRCB_IMM;
                    w_ctrl.alu_op    = ALUOP_RI;
                end
                EXEC_LUI: begin
                    w_ctrl.alu_src_b = SRCB_IMM;
                    w_ctrl.alu_op    = ALUOP_JL;
                end
                ALU_WB: begin
                    w_ctrl.result_src    = RES_ALUOUT;
                    w_ctrl.reg_write     = 1'b1;
                    w_ctrl.instr_retired = 1'b1;
                end
                BRANCH: begin
                    w_ctrl.alu_src_a     = SRCA_RS1;
                    w_ctrl.alu_src_b     = SRCB_RS2;
                    w_ctrl.alu_op        = ALUOP_BR;
                    w_ctrl.result_src    = RES_ALUOUT;
                    w_ctrl.pc_write_cond = 1'b1;
                    w_ctrl.instr_retired = 1'b1;
                end
                JAL: begin
                    w_ctrl.alu_src_a     = SRCA_OLDPC;
                    w_ctrl.alu_src_b     = SRCB_FOUR;
                    w_ctrl.alu_op        = ALUOP_JL;
                    w_ctrl.result_src    = RES_ALURESULT;
                    w_ctrl.reg_write     = 1'b1;
                    w_ctrl.pc_write      = 1'b1;
                    w_ctrl.instr_retired = 1'b1;
                end
                TRAP:    w_ctrl.illegal_instr = 1'b1;
                default: w_ctrl = '0;
            endcase
        end
    end

    // The timer restarts whenever a memory-handshake state is newly entered.
    assign w_timer_clear   = (w_state_next != r_state) &&
                             ((w_state_next == FETCH) || (w_state_next == MEM_READ) ||
                              (w_state_next == MEM_WRITE));
    assign w_timer_waiting = w_ctrl.mem_req && !MemReady;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (w_timer_clear),
        .waiting (w_timer_waiting),
        .expired (w_timer_expired)
    );

    assign ALUOp        = w_ctrl.alu_op;
    assign ALUSrcA      = w_ctrl.alu_src_a;
    assign ALUSrcB      = w_ctrl.alu_src_b;
    assign ResultSrc    = w_ctrl.result_src;
    assign AdrSrc       = w_ctrl.adr_src;
    assign MemReq       = w_ctrl.mem_req;
    assign MemWrite     = w_ctrl.mem_write;
    assign IRWrite      = w_ctrl.ir_write;
    assign PCWrite      = w_ctrl.pc_write;
    assign PCWriteCond  = w_ctrl.pc_write_cond;
    assign RegWrite     = w_ctrl.reg_write;
    assign InstrRetired = w_ctrl.instr_retired;
    assign IllegalInstr = w_ctrl.illegal_instr;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: each instruction class is expanded into its expected
// per-cycle control script and compared against the controller cycle by cycle.
module tb_multicycle_controller;

    localparam int TB_TO = 4;

    localparam logic [6:0] C_LW   = 7'b0000011;
    localparam logic [6:0] C_SW   = 7'b0100011;
    localparam logic [6:0] C_ADD  = 7'b0110011;
    localparam logic [6:0] C_ADDI = 7'b0010011;
    localparam logic [6:0] C_LUI  = 7'b0110111;
    localparam logic [6:0] C_AUI  = 7'b0010111;
    localparam logic [6:0] C_BEQ  = 7'b1100011;
    localparam logic [6:0] C_JAL  = 7'b1101111;
    localparam logic [6:0] C_JALR = 7'b1100111;

    // Flag order: AdrSrc MemReq MemWrite IRWrite PCWrite PCWriteCond RegWrite InstrRetired IllegalInstr
    localparam logic [8:0] F_ADR = 9'h100;
    localparam logic [8:0] F_REQ = 9'h080;
    localparam logic [8:0] F_MW  = 9'h040;
    localparam logic [8:0] F_IRW = 9'h020;
    localparam logic [8:0] F_PCW = 9'h010;
    localparam logic [8:0] F_PCC = 9'h008;
    localparam logic [8:0] F_RW  = 9'h004;
    localparam logic [8:0] F_RET = 9'h002;
    localparam logic [8:0] F_ILL = 9'h001;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] Opcode = 7'd0;
    logic       MemReady = 1'b0;
    logic [1:0] ALUOp, ALUSrcA, ALUSrcB, ResultSrc;
    logic       AdrSrc, MemReq, MemWrite, IRWrite, PCWrite, PCWriteCond;
    logic       RegWrite, InstrRetired, IllegalInstr;
    logic [16:0] w_obs;

    int n_checks = 0;
    int n_errors = 0;

    multicycle_controller #(.MEM_TIMEOUT(TB_TO)) dut (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .MemReady(MemReady),
        .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .AdrSrc(AdrSrc), .MemReq(MemReq), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .RegWrite(RegWrite),
        .InstrRetired(InstrRetired), .IllegalInstr(IllegalInstr)
    );

    always #5 clk = ~clk;

    assign w_obs = {ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, MemReq, MemWrite,
                    IRWrite, PCWrite, PCWriteCond, RegWrite, InstrRetired, IllegalInstr};

    function automatic logic [16:0] ctl(input logic [1:0] aop, input logic [1:0] sa,
                                        input logic [1:0] sb, input logic [1:0] rs,
                                        input logic [8:0] fl);
        return {aop, sa, sb, rs, fl};
    endfunction

    logic [16:0] e_fwait, e_fdone, e_dec, e_ma, e_mrd, e_mwb, e_mwr, e_mwr_done;
    logic [16:0] e_exr, e_exi, e_lui, e_aui, e_awb, e_br, e_jal, e_jr, e_trap;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] rnd_op();
        return 7'($urandom);
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // One clock cycle: drive inputs, compare on the falling edge, advance.
    task automatic cyc(input string tag, input logic rdy, input logic [6:0] op,
                       input logic [16:0] exp);
        MemReady = rdy;
        Opcode   = op;
        @(negedge clk);
        check_eq(tag, {15'd0, w_obs}, {15'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        MemReady = 1'b1;
        Opcode   = rnd_op();
        @(negedge clk);
        check_eq("reset_outputs", {15'd0, w_obs}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Full instruction with fw/mw cycles of memory wait (each at most TB_TO).
    task automatic run_instr(input logic [6:0] op, input int fw, input int mw);
        for (int k = 0; k < fw; k++) cyc("fetch_wait", 1'b0, rnd_op(), e_fwait);
        cyc("fetch_done", 1'b1, rnd_op(), e_fdone);
        cyc("decode", rnd_bit(), op, e_dec);
        case (op)
            C_LW: begin
                cyc("mem_addr", rnd_bit(), op, e_ma);
                for (int k = 0; k < mw; k++) cyc("mem_read_wait", 1'b0, rnd_op(), e_mrd);
                cyc("mem_read_done", 1'b1, rnd_op(), e_mrd);
                cyc("mem_wb", rnd_bit(), rnd_op(), e_mwb);
            end
            C_SW: begin
                cyc("mem_addr", rnd_bit(), op, e_ma);
                for (int k = 0; k < mw; k++) cyc("mem_write_wait", 1'b0, rnd_op(), e_mwr);
                cyc("mem_write_done", 1'b1, rnd_op(), e_mwr_done);
            end
            C_ADD:  begin cyc("exec_r", rnd_bit(), rnd_op(), e_exr); cyc("alu_wb", rnd_bit(), rnd_op(), e_awb); end
            C_ADDI: begin cyc("exec_i", rnd_bit(), rnd_op(), e_exi); cyc("alu_wb", rnd_bit(), rnd_op(), e_awb); end
            C_LUI:  begin cyc("exec_lui", rnd_bit(), rnd_op(), e_lui); cyc("alu_wb", rnd_bit(), rnd_op(), e_awb); end
            C_AUI:  begin cyc("exec_auipc", rnd_bit(), rnd_op(), e_aui); cyc("alu_wb", rnd_bit(), rnd_op(), e_awb); end
            C_BEQ:  cyc("branch", rnd_bit(), rnd_op(), e_br);
            C_JAL:  cyc("jal", rnd_bit(), rnd_op(), e_jal);
            C_JALR: begin cyc("exec_jalr", rnd_bit(), rnd_op(), e_jr); cyc("jalr_link", rnd_bit(), rnd_op(), e_jal); end
            default: begin
                for (int k = 0; k < 20; k++) cyc("trap_hold", rnd_bit(), rnd_op(), e_trap);
                do_reset();
            end
        endcase
    endtask

    logic [6:0] legal_ops [9];

    initial begin
        e_fwait    = ctl(2'd0, 2'd0, 2'd2, 2'd0, F_REQ);
        e_fdone    = ctl(2'd0, 2'd0, 2'd2, 2'd0, F_REQ | F_IRW | F_PCW);
        e_dec      = ctl(2'd0, 2'd1, 2'd1, 2'd0, 9'd0);
        e_ma       = ctl(2'd0, 2'd2, 2'd1, 2'd0, 9'd0);
        e_mrd      = ctl(2'd0, 2'd0, 2'd0, 2'd0, F_REQ | F_ADR);
        e_mwb      = ctl(2'd0, 2'd0, 2'd0, 2'd1, F_RW | F_RET);
        e_mwr      = ctl(2'd0, 2'd0, 2'd0, 2'd0, F_REQ | F_MW | F_ADR);
        e_mwr_done = ctl(2'd0, 2'd0, 2'd0, 2'd0, F_REQ | F_MW | F_ADR | F_RET);
        e_exr      = ctl(2'd2, 2'd2, 2'd0, 2'd0, 9'd0);
        e_exi      = ctl(2'd2, 2'd2, 2'd1, 2'd0, 9'd0);
        e_lui      = ctl(2'd3, 2'd0, 2'd1, 2'd0, 9'd0);
        e_aui      = ctl(2'd0, 2'd1, 2'd1, 2'd0, 9'd0);
        e_awb      = ctl(2'd0, 2'd0, 2'd0, 2'd0, F_RW | F_RET);
        e_br       = ctl(2'd1, 2'd2, 2'd0, 2'd0, F_PCC | F_RET);
        e_jal      = ctl(2'd3, 2'd1, 2'd2, 2'd2, F_RW | F_PCW | F_RET);
        e_jr       = ctl(2'd0, 2'd2, 2'd1, 2'd0, 9'd0);
        e_trap     = ctl(2'd0, 2'd0, 2'd0, 2'd0, F_ILL);
        legal_ops  = '{C_LW, C_SW, C_ADD, C_ADDI, C_LUI, C_AUI, C_BEQ, C_JAL, C_JALR};

        @(posedge clk);
        #1;
        do_reset();

        run_instr(C_ADD, 0, 0);
        run_instr(C_LW, 3, 3);
        run_instr(C_BEQ, 0, 0);
        run_instr(C_JALR, 0, 0);
        run_instr(7'b1111111, 0, 0);

        // Memory stuck in FETCH: TB_TO counted wait cycles, then trap.
        for (int k = 0; k <= TB_TO; k++) cyc("fetch_to_wait", 1'b0, rnd_op(), e_fwait);
        for (int k = 0; k < 3; k++) cyc("fetch_to_trap", rnd_bit(), rnd_op(), e_trap);
        do_reset();
        // Ready arriving exactly at the limit completes normally.
        run_instr(C_ADD, TB_TO, 0);
        run_instr(C_SW, 1, TB_TO);

        // Load whose data never arrives.
        cyc("fetch_done", 1'b1, rnd_op(), e_fdone);
        cyc("decode", 1'b0, C_LW, e_dec);
        cyc("mem_addr", 1'b0, C_LW, e_ma);
        for (int k = 0; k <= TB_TO; k++) cyc("read_to_wait", 1'b0, rnd_op(), e_mrd);
        for (int k = 0; k < 3; k++) cyc("read_to_trap", rnd_bit(), rnd_op(), e_trap);
        do_reset();

        // Reset in the middle of a load abandons it.
        cyc("fetch_done", 1'b1, rnd_op(), e_fdone);
        cyc("decode", 1'b0, C_LW, e_dec);
        cyc("mem_addr", 1'b0, C_LW, e_ma);
        cyc("mem_read_wait", 1'b0, rnd_op(), e_mrd);
        do_reset();
        run_instr(C_ADDI, 0, 0);

        for (int n = 0; n < 80; n++) begin
            logic [6:0] op;
            if ($urandom_range(0, 11) == 0) begin
                op = 7'b0000000;
            end else begin
                op = legal_ops[$urandom_range(0, 8)];
            end
            run_instr(op, $urandom_range(0, TB_TO), $urandom_range(0, TB_TO));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Main control FSM for the multicycle RISC-V datapath. It is the stage directly upstream of ALUController and produces the 2-bit ALUOp that ALUController combines with Funct3/Funct7. It sequences fetch, decode, execute, memory and writeback for RV32I base opcodes. It drives all datapath mux selects and write enables, and handshakes with a variable-latency memory.

Parameters:
MEM_TIMEOUT, 255, maximum cycles spent waiting for MemReady in any memory state before trapping; 0 disables the timeout.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
Opcode  input  7  instruction bits [6:0], taken from the instruction register
MemReady  input  1  memory completes the current MemReq this cycle
ALUOp  output  2  00 LW/SW/AUIPC/address add; 01 branch compare; 10 R/I-type; 11 JAL/LUI
ALUSrcA  output  2  0 PC, 1 OldPC, 2 rs1
ALUSrcB  output  2  0 rs2, 1 imm, 2 constant 4
ResultSrc  output  2  0 ALUOut, 1 MemData, 2 ALUResult
AdrSrc  output  1  0 PC, 1 ALUOut (memory address select)
MemReq  output  1  memory request, held until MemReady
MemWrite  output  1  store qualifier, valid with MemReq
IRWrite  output  1  load instruction register
PCWrite  output  1  unconditional PC update
PCWriteCond  output  1  PC update qualified by the branch outcome outside this block
RegWrite  output  1  register file write
InstrRetired  output  1  one-cycle pulse when an instruction completes
IllegalInstr  output  1  sticky trap flag (unknown opcode or memory timeout)

Behaviour:
- State enum: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, EXEC_LUI, EXEC_AUIPC, ALU_WB, BRANCH, JAL, EXEC_JALR, TRAP.
- Outputs are decoded from the state, with one exception: FETCH IRWrite/PCWrite also depend on MemReady. Every output not listed for a state is 0.
- While rst_n is low: state=FETCH and every output is forced to 0. Reset asserted mid-instruction abandons it with no partial writes.
- FETCH: MemReq=1, AdrSrc=0, ALUSrcA=0, ALUSrcB=2, ALUOp=00. The state holds until MemReady. In the MemReady cycle IRWrite=1 and PCWrite=1, and the next state is DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=1, ALUOp=00 (target precompute into ALUOut). Next state by Opcode:
  - 0000011 or 0100011 → MEM_ADDR
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0110111 → EXEC_LUI
  - 0010111 → EXEC_AUIPC
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → EXEC_JALR
  - anything else → TRAP
- MEM_ADDR: ALUSrcA=2, ALUSrcB=1, ALUOp=00. Next is MEM_READ for a load, MEM_WRITE for a store.
- MEM_READ: MemReq=1, AdrSrc=1. On MemReady go to MEM_WB.
- MEM_WB: ResultSrc=1, RegWrite=1, InstrRetired=1. Next FETCH.
- MEM_WRITE: MemReq=1, MemWrite=1, AdrSrc=1. On MemReady: InstrRetired=1, next FETCH.
- EXEC_R: ALUSrcA=2, ALUSrcB=0, ALUOp=10.
- EXEC_I: ALUSrcA=2, ALUSrcB=1, ALUOp=10.
- EXEC_LUI: ALUSrcB=1, ALUOp=11.
- EXEC_AUIPC: ALUSrcA=1, ALUSrcB=1, ALUOp=00.
- EXEC_R, EXEC_I, EXEC_LUI and EXEC_AUIPC all go next to ALU_WB.
- ALU_WB: ResultSrc=0, RegWrite=1, InstrRetired=1. Next FETCH.
- BRANCH: ALUSrcA=2, ALUSrcB=0, ALUOp=01, ResultSrc=0, PCWriteCond=1, InstrRetired=1. Next FETCH.
- JAL: ALUSrcA=1, ALUSrcB=2, ALUOp=11, ResultSrc=2, RegWrite=1, PCWrite=1, InstrRetired=1. The PC takes ALUOut (target from DECODE). Next FETCH.
- EXEC_JALR: ALUSrcA=2, ALUSrcB=1, ALUOp=00 (target into ALUOut). Next JAL, which performs the link write and PC update.
- Latency in cycles, excluding memory wait: load 5, store 4, R/I/LUI/AUIPC 4, branch 3, JAL 3, JALR 4.
- Memory wait timer:
  - Clears on entry to FETCH, MEM_READ and MEM_WRITE, and increments each cycle MemReq=1 and MemReady=0.
  - When it reaches MEM_TIMEOUT with MemReady still 0, the next state is TRAP.
  - MemReady in the same cycle as the timeout wins: the access completes normally.
  - Counter width is $clog2(MEM_TIMEOUT+1). With MEM_TIMEOUT=0 the counter is not instantiated.
- TRAP: IllegalInstr=1. All other outputs are 0. The state is absorbing until rst_n is asserted.
- Opcode is sampled only in DECODE and MEM_ADDR. Changes in other states are ignored.

Decomposition:
- riscv_ctrl_pkg holds:
  - the state enum
  - the RV32I opcode localparams
  - the ALUOp encodings (ALUOP_ADD, ALUOP_BR, ALUOP_RI, ALUOP_JL)
  - the ALUSrcA, ALUSrcB and ResultSrc select encodings
- One sub-module: mem_wait_timer (parameter MEM_TIMEOUT; inputs clk, rst_n, clear, waiting; output expired).

Test Plan:
- Reset then ADD (Opcode 0110011), MemReady=1 in the first FETCH cycle → states FETCH, DECODE, EXEC_R, ALU_WB. ALUOp=10 in EXEC_R; RegWrite and InstrRetired high only in ALU_WB.
- LW (0000011), MemReady delayed 3 cycles in both FETCH and MEM_READ → MemReq held high throughout the wait. ResultSrc=1 and RegWrite=1 one cycle after MEM_READ's MemReady. Total 11 cycles.
- BEQ (1100011) → BRANCH reached on cycle 3 with ALUOp=01 and PCWriteCond=1. PCWrite=0 outside FETCH.
- JALR (1100111) → EXEC_JALR with ALUOp=00, then JAL with RegWrite=1, PCWrite=1, ResultSrc=2.
- Opcode 1111111 → TRAP after DECODE, IllegalInstr=1 held for 20 cycles. rst_n pulse returns to FETCH with IllegalInstr=0.
- MEM_TIMEOUT=4, MemReady stuck low in FETCH → TRAP after 4 wait cycles. Rerun with MemReady rising exactly at count 4 → DECODE, no trap.
